// File: rtl/countermod7_sequencer_if.sv
// rtl/countermod7_sequencer_if.sv - command, counter-feedback and status bundle for countermod7_sequencer
interface countermod7_sequencer_if #(
    parameter int LAP_W = 4
);
    logic             start;
    logic             stop;
    logic             step;
    logic [2:0]       counter_value;
    logic             enable;
    logic             wrap;
    logic [LAP_W-1:0] lap_count;
    logic [1:0]       state;
    logic             done;

    // Board/command side: issues commands, reports the counter value, observes status.
    modport master (
        output start, stop, step, counter_value,
        input  enable, wrap, lap_count, state, done
    );

    // Sequencer side.
    modport slave (
        input  start, stop, step, counter_value,
        output enable, wrap, lap_count, state, done
    );
endinterface

// File: rtl/countermod7_sequencer.sv
// rtl/countermod7_sequencer.sv - run/pause/step sequencer for a mod-7 counter (optional LAP_LIMIT_EN)
module countermod7_sequencer #(
    parameter int TICK_DIV = 4,
    parameter int MAX_LAPS = 3,
    parameter int LAP_W    = 4
) (
    input logic                   clock,
    input logic                   reset,
    countermod7_sequencer_if.slave bus
);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0]    TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [LAP_W-1:0] LAP_SAT   = '1;
    localparam logic [LAP_W:0]   LAP_LIMIT = (LAP_W + 1)'(MAX_LAPS);
`ifdef LAP_LIMIT_EN
    localparam bit LIMIT_ON = 1'b1;
`else
    localparam bit LIMIT_ON = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_STEP  = 2'b11
    } state_t;

    state_t           state_q;
    logic [TW-1:0]    tick_cnt;
    logic             enable_q;
    logic             wrap_q;
    logic             done_q;
    logic [LAP_W-1:0] lap_q;

    logic             wrap_hit;
    logic             limit_hit;
    logic [LAP_W:0]   lap_next_wide;

    // The counter advances on this edge from 6 to 0; 7 is never a wrap.
    always_comb begin
        wrap_hit      = enable_q && (bus.counter_value == 3'b110);
        lap_next_wide = {1'b0, lap_q} + (LAP_W + 1)'(1);
        limit_hit     = LIMIT_ON && wrap_hit && (lap_next_wide == LAP_LIMIT);
    end

    // Sequencer FSM, prescaler, wrap/lap tracking; every output is a register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            tick_cnt <= '0;
            enable_q <= 1'b0;
            wrap_q   <= 1'b0;
            done_q   <= 1'b0;
            lap_q    <= '0;
        end else begin
            wrap_q   <= wrap_hit;
            done_q   <= limit_hit;
            enable_q <= 1'b0;

            if (wrap_hit && (lap_q != LAP_SAT)) begin
                lap_q <= lap_q + LAP_W'(1);
            end

            // The highest-priority command (stop > start > step) is chosen first;
            // if it is not legal in the current state, nothing happens.
            case (state_q)
                S_IDLE: begin
                    if (bus.stop) begin
                        state_q <= S_IDLE;
                    end else if (bus.start) begin
                        state_q  <= S_RUN;
                        tick_cnt <= '0;
                        lap_q    <= '0;
                    end else if (bus.step) begin
                        state_q  <= S_STEP;
                        enable_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (bus.stop) begin
                        state_q <= S_PAUSE;
                    end else if (tick_cnt == TICK_LAST) begin
                        tick_cnt <= '0;
                        enable_q <= 1'b1;
                    end else begin
                        tick_cnt <= tick_cnt + TW'(1);
                    end
                end
                S_PAUSE: begin
                    if (bus.stop) begin
                        state_q  <= S_IDLE;
                        tick_cnt <= '0;
                    end else if (bus.start) begin
                        state_q <= S_RUN;
                    end else if (bus.step) begin
                        state_q  <= S_STEP;
                        enable_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_PAUSE;
                end
            endcase

            // Lap-limit auto-stop overrides both the command decode and the prescaler.
            if (limit_hit) begin
                state_q  <= S_IDLE;
                enable_q <= 1'b0;
            end
        end
    end

    assign bus.enable    = enable_q;
    assign bus.wrap      = wrap_q;
    assign bus.lap_count = lap_q;
    assign bus.state     = state_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_countermod7_sequencer.sv
// tb/tb_countermod7_sequencer.sv - directed scoreboard bench for countermod7_sequencer
module tb_countermod7_sequencer;
    localparam int TICK_DIV = 4;
    localparam int MAX_LAPS = 3;
    localparam int LAP_W    = 4;

    logic clock;
    logic reset;

    countermod7_sequencer_if #(.LAP_W(LAP_W)) bus ();

    countermod7_sequencer #(
        .TICK_DIV(TICK_DIV),
        .MAX_LAPS(MAX_LAPS),
        .LAP_W   (LAP_W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    // Behavioural mod-7 counter driven by the sequencer's enable.
    logic [2:0] cv;
    logic       cv_load;
    logic [2:0] cv_load_val;
    int         ecnt;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            cv <= 3'd0;
        end else if (cv_load) begin
            cv <= cv_load_val;
        end else if (bus.enable) begin
            cv <= (cv == 3'd6) ? 3'd0 : cv + 3'd1;
        end
    end

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            ecnt <= 0;
        end else if (bus.enable) begin
            ecnt <= ecnt + 1;
        end
    end

    assign bus.counter_value = cv;

    typedef struct {
        string tag;
        int    val;
    } exp_t;

    exp_t sb[$];
    int   checks;
    int   errors;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_v(input string tag, input int val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    function automatic int observe(input string tag);
        case (tag)
            "state":  return int'(bus.state);
            "enable": return int'(bus.enable);
            "wrap":   return int'(bus.wrap);
            "lap":    return int'(bus.lap_count);
            "done":   return int'(bus.done);
            "cv":     return int'(cv);
            "ecnt":   return ecnt;
            default:  return -1;
        endcase
    endfunction

    task automatic check_sb();
        exp_t e;
        int   obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.tag);
            checks++;
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed %0d expected %0d", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic expect_all_zero();
        expect_v("state", 0);
        expect_v("enable", 0);
        expect_v("wrap", 0);
        expect_v("lap", 0);
        expect_v("done", 0);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        clock       = 1'b0;
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.stop    = 1'b0;
        bus.step    = 1'b0;
        cv_load     = 1'b0;
        cv_load_val = 3'd0;

        // Reset state
        #1;
        expect_all_zero();
        check_sb();
        #20 reset = 1'b0;
        tick();
        expect_all_zero();
        check_sb();

        // 1: start, enable every 4th cycle, first wrap after 7 enables
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        expect_v("state", 1);
        expect_v("enable", 0);
        check_sb();
        for (int k = 1; k <= 29; k++) begin
            tick();
            expect_v("enable", (k % 4 == 0) ? 1 : 0);
            expect_v("wrap", (k == 29) ? 1 : 0);
            if (k == 29) begin
                expect_v("lap", 1);
                expect_v("cv", 0);
                expect_v("ecnt", 7);
            end
            check_sb();
        end

        // 2: stop while enable is high, pause, resume from held tick_cnt
        tick();
        tick();
        tick();
        expect_v("enable", 1);
        check_sb();
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        expect_v("state", 2);
        expect_v("enable", 0);
        expect_v("ecnt", 8);
        expect_v("cv", 1);
        check_sb();
        for (int k = 0; k < 5; k++) begin
            tick();
            expect_v("state", 2);
            expect_v("enable", 0);
            check_sb();
        end
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        expect_v("state", 1);
        expect_v("enable", 0);
        check_sb();
        for (int k = 1; k <= 4; k++) begin
            tick();
            expect_v("enable", (k == 4) ? 1 : 0);
            check_sb();
        end
        bus.stop = 1'b1;
        tick();
        expect_v("state", 2);
        expect_v("ecnt", 9);
        check_sb();
        tick();
        bus.stop = 1'b0;
        expect_v("state", 0);
        expect_v("lap", 1);
        expect_v("enable", 0);
        check_sb();

        // 3: step from IDLE with counter at 6; commands during STEP ignored
        reset = 1'b1;
        #2 reset = 1'b0;
        cv_load     = 1'b1;
        cv_load_val = 3'd6;
        tick();
        cv_load = 1'b0;
        bus.step = 1'b1;
        tick();
        bus.step  = 1'b0;
        bus.start = 1'b1;
        expect_v("state", 3);
        expect_v("enable", 1);
        expect_v("lap", 0);
        check_sb();
        tick();
        bus.start = 1'b0;
        expect_v("state", 2);
        expect_v("enable", 0);
        expect_v("wrap", 1);
        expect_v("lap", 1);
        expect_v("cv", 0);
        check_sb();
        tick();
        expect_v("wrap", 0);
        expect_v("state", 2);
        expect_v("lap", 1);
        check_sb();

        // 4: all commands at once in RUN -> PAUSE only
        bus.start = 1'b1;
        tick();
        expect_v("state", 1);
        check_sb();
        bus.stop = 1'b1;
        bus.step = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.step  = 1'b0;
        expect_v("state", 2);
        expect_v("enable", 0);
        check_sb();
        tick();
        expect_v("state", 2);
        expect_v("enable", 0);
        check_sb();

        // 5: three laps; auto-stop only with the lap limit enabled
        reset = 1'b1;
        #2 reset = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 1; k <= 84; k++) begin
            tick();
            expect_v("enable", (k % 4 == 0) ? 1 : 0);
            expect_v("done", 0);
            check_sb();
        end
        expect_v("ecnt", 20);
        check_sb();
        tick();
        expect_v("ecnt", 21);
        expect_v("wrap", 1);
        expect_v("lap", 3);
        expect_v("enable", 0);
`ifdef LAP_LIMIT_EN
        expect_v("done", 1);
        expect_v("state", 0);
`else
        expect_v("done", 0);
        expect_v("state", 1);
`endif
        check_sb();
        for (int k = 86; k <= 89; k++) begin
            tick();
            expect_v("done", 0);
`ifdef LAP_LIMIT_EN
            expect_v("enable", 0);
            expect_v("state", 0);
`else
            expect_v("enable", (k == 88) ? 1 : 0);
            expect_v("state", 1);
`endif
            check_sb();
        end
`ifdef LAP_LIMIT_EN
        expect_v("ecnt", 21);
`else
        expect_v("ecnt", 22);
`endif
        check_sb();

        // 6: asynchronous reset between edges while running with a nonzero lap count
`ifndef LAP_LIMIT_EN
        bus.stop = 1'b1;
        tick();
        tick();
        bus.stop = 1'b0;
`endif
        expect_v("state", 0);
        expect_v("lap", 3);
        check_sb();
        bus.step = 1'b1;
        tick();
        bus.step = 1'b0;
        expect_v("state", 3);
        check_sb();
        tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        expect_v("state", 1);
        expect_v("lap", 3);
        check_sb();
        tick();
        tick();
        #2 reset = 1'b1;
        #1;
        expect_all_zero();
        check_sb();
        tick();
        expect_all_zero();
        check_sb();
        reset = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        expect_v("state", 1);
        check_sb();
        for (int k = 1; k <= 4; k++) begin
            tick();
            expect_v("enable", (k == 4) ? 1 : 0);
            check_sb();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
